// File: rtl/uart_rx_mon.sv
`timescale 1ns/1ps
// uart_rx_mon: oversampling UART receiver with a character FIFO and sticky status.
// Frame format: 1 start bit, DATA_BITS data bits sent LSB first, an optional
// parity bit, and STOP_BITS stop bits. Each received character is stored in
// the FIFO together with its framing-error and parity-error flags.
// Optional build macro: UART_RX_MON_BREAK_DET_EN adds the brk output and
// break-condition handling.
module uart_rx_mon #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUDRATE   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                 clk_100M,
  input  logic                 ck_rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ferr,
  output logic                 rx_perr,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 ovr,
  input  logic                 clr,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic                 busy
`ifdef UART_RX_MON_BREAK_DET_EN
  ,
  output logic                 brk
`endif
);

  // Clock cycles per bit, rounded to the nearest integer.
  localparam int DIV = (CLK_HZ + BAUDRATE / 2) / BAUDRATE;
  localparam int TW  = $clog2(DIV);
  localparam logic [TW-1:0] HALF     = TW'(DIV / 2);
  localparam logic [TW-1:0] LAST_CNT = TW'(DIV - 1);
  localparam logic [3:0] LAST_DBIT   = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_SBIT   = 4'(STOP_BITS - 1);
  localparam logic       PAR_ODD     = (PARITY == 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
`ifdef UART_RX_MON_BREAK_DET_EN
    S_BRK,
`endif
    S_PUSH
  } state_t;

  state_t               state;
  logic                 sync1;
  logic                 rxs;
  logic                 rxs_d;
  logic [TW-1:0]        timer;
  logic                 sample;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr_r;
  logic                 perr_r;
  logic                 par_err;
`ifdef UART_RX_MON_BREAK_DET_EN
  logic                 all_zero;
  logic                 brk_r;
`endif

  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push_req;
  logic                 push_ok;
  logic                 pop;
  logic [EW-1:0]        head;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk_100M) begin
    if (!ck_rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  // Bit timer: held at zero while idle, free-running 0..DIV-1 inside a frame.
  always_ff @(posedge clk_100M) begin
    if (!ck_rst_n || state == S_IDLE) begin
      timer <= '0;
    end else if (timer == LAST_CNT) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  assign sample = (timer == HALF);

  // Received parity mismatch: XOR over data plus parity bit must be 1 (odd) or 0 (even).
  assign par_err = PAR_ODD ? ~(^shreg ^ rxs) : (^shreg ^ rxs);

  // Frame decoder FSM.
  always_ff @(posedge clk_100M) begin
    if (!ck_rst_n) begin
      state   <= S_IDLE;
      bit_idx <= '0;
      shreg   <= '0;
      ferr_r  <= 1'b0;
      perr_r  <= 1'b0;
`ifdef UART_RX_MON_BREAK_DET_EN
      all_zero <= 1'b0;
      brk_r    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (rxs_d && !rxs) begin
            state <= S_START;
          end
        end
        S_START: begin
          if (sample) begin
            if (rxs) begin
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              bit_idx <= '0;
              ferr_r  <= 1'b0;
              perr_r  <= 1'b0;
`ifdef UART_RX_MON_BREAK_DET_EN
              all_zero <= 1'b1;
`endif
            end
          end
        end
        S_DATA: begin
          if (sample) begin
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
`ifdef UART_RX_MON_BREAK_DET_EN
            all_zero <= all_zero & ~rxs;
`endif
            if (bit_idx == LAST_DBIT) begin
              bit_idx <= '0;
              state   <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        S_PAR: begin
          if (sample) begin
            perr_r <= par_err;
`ifdef UART_RX_MON_BREAK_DET_EN
            all_zero <= all_zero & ~rxs;
`endif
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (sample) begin
            if (!rxs) begin
              ferr_r <= 1'b1;
            end
`ifdef UART_RX_MON_BREAK_DET_EN
            all_zero <= all_zero & ~rxs;
`endif
            if (bit_idx == LAST_SBIT) begin
              state <= S_PUSH;
`ifdef UART_RX_MON_BREAK_DET_EN
              // Break decision is registered on entry to PUSH so brk is high during PUSH.
              brk_r <= all_zero & ~rxs;
`endif
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        S_PUSH: begin
`ifdef UART_RX_MON_BREAK_DET_EN
          brk_r <= 1'b0;
          state <= brk_r ? S_BRK : S_IDLE;
`else
          state <= S_IDLE;
`endif
        end
`ifdef UART_RX_MON_BREAK_DET_EN
        S_BRK: begin
          if (rxs) begin
            state <= S_IDLE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
`ifdef UART_RX_MON_BREAK_DET_EN
  assign brk      = brk_r;
  assign push_req = (state == S_PUSH) && !brk_r;
`else
  assign push_req = (state == S_PUSH);
`endif

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = rx_valid && rx_ready;
  // A same-cycle pop frees the slot the push lands in, so a full FIFO still accepts.
  assign push_ok    = push_req && (!fifo_full || pop);

  // FIFO storage; contents need no reset because the outputs are gated by rx_valid.
  always_ff @(posedge clk_100M) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= {shreg, ferr_r, perr_r};
    end
  end

  // FIFO pointers, wrapping naturally with one extra bit for full/empty.
  always_ff @(posedge clk_100M) begin
    if (!ck_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Sticky overrun flag and frame counter; clr wins over a same-cycle update.
  always_ff @(posedge clk_100M) begin
    if (!ck_rst_n) begin
      ovr       <= 1'b0;
      frame_cnt <= '0;
    end else if (clr) begin
      ovr       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (push_req && fifo_full && !pop) begin
        ovr <= 1'b1;
      end
      if (state == S_PUSH) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

  assign head     = mem[rd_ptr[AW-1:0]];
  assign rx_valid = !fifo_empty;
  assign rx_data  = rx_valid ? head[EW-1:2] : '0;
  assign rx_ferr  = rx_valid ? head[1] : 1'b0;
  assign rx_perr  = rx_valid ? head[0] : 1'b0;

endmodule

// File: tb/tb_uart_rx_mon.sv
`timescale 1ns/1ps
// Self-checking bench for uart_rx_mon: 8 data bits, even parity, 1 stop bit, DIV = 16.
module tb_uart_rx_mon;

  localparam int CLK_HZ   = 8000000;
  localparam int BAUDRATE = 500000;
  localparam int DIV      = (CLK_HZ + BAUDRATE / 2) / BAUDRATE;
  localparam int NB       = 11;
  localparam int DEPTH    = 8;
  // Negedge index (from the start-bit drive) that falls inside the PUSH cycle:
  // 2 sync flops + edge detect, half-bit to the start sample, then NB-1 bit periods.
  localparam int PUSH_C   = DIV / 2 + 4 + (NB - 1) * DIV;

  logic        clk_100M = 1'b0;
  logic        ck_rst_n;
  logic        rxd;
  logic [7:0]  rx_data;
  logic        rx_ferr;
  logic        rx_perr;
  logic        rx_valid;
  logic        rx_ready;
  logic        ovr;
  logic        clr;
  logic [15:0] frame_cnt;
  logic        busy;
`ifdef UART_RX_MON_BREAK_DET_EN
  logic        brk;
  int          brk_cnt = 0;
  int          exp_brk = 0;
`endif

  uart_rx_mon #(
    .CLK_HZ     (CLK_HZ),
    .BAUDRATE   (BAUDRATE),
    .DATA_BITS  (8),
    .PARITY     (2),
    .STOP_BITS  (1),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (16)
  ) dut (
    .clk_100M  (clk_100M),
    .ck_rst_n  (ck_rst_n),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_ferr   (rx_ferr),
    .rx_perr   (rx_perr),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .ovr       (ovr),
    .clr       (clr),
    .frame_cnt (frame_cnt),
    .busy      (busy)
`ifdef UART_RX_MON_BREAK_DET_EN
    ,
    .brk       (brk)
`endif
  );

  always #5 clk_100M = ~clk_100M;

`ifdef UART_RX_MON_BREAK_DET_EN
  always @(negedge clk_100M) if (brk === 1'b1) brk_cnt++;
`endif

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] d;
    bit         f;
    bit         p;
  } ent_t;

  typedef struct {
    logic [7:0] d;
    bit         pb;
    bit         sb;
    logic [7:0] ed;
    bit         ef;
    bit         ep;
  } tv_t;

  ent_t q[$];
  int   exp_cnt = 0;
  bit   exp_ovr = 0;
  logic v_push, v_after;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive one frame; pb flips the correct even-parity bit, sb forces the stop bit low.
  task automatic send_frame(input logic [7:0] d, input bit pb, input bit sb, input int tail,
                            input int pop_at, input int clr_at, input int abort_at);
    logic [10:0] bits;
    int          lim;
    bits = {~sb, (^d) ^ pb, d, 1'b0};
    lim  = (abort_at >= 0) ? abort_at : NB * DIV;
    for (int c = 0; c < lim; c++) begin
      @(negedge clk_100M);
      if (c == PUSH_C)     v_push  = rx_valid;
      if (c == PUSH_C + 1) v_after = rx_valid;
      rxd      = bits[c / DIV];
      rx_ready = (c == pop_at);
      clr      = (c == clr_at);
    end
    if (abort_at < 0) begin
      for (int t = 0; t < tail; t++) begin
        @(negedge clk_100M);
        rxd = 1'b1; rx_ready = 1'b0; clr = 1'b0;
      end
      rxd = (tail > 0) ? 1'b1 : rxd;
    end
    rx_ready = 1'b0;
    clr      = 1'b0;
  endtask

  // Reference: every frame counts; break frames (feature on) never reach the FIFO;
  // a full FIFO drops the entry and flags overrun unless the same cycle pops.
  function automatic void model_frame(input logic [7:0] d, input bit pb, input bit sb,
                                      input bit simul_pop);
    ent_t e;
    exp_cnt++;
`ifdef UART_RX_MON_BREAK_DET_EN
    if (d == 8'h00 && !pb && sb) begin
      exp_brk++;
      return;
    end
`endif
    e.d = d; e.f = sb; e.p = pb;
    if (simul_pop && q.size() > 0) void'(q.pop_front());
    if (q.size() < DEPTH) q.push_back(e);
    else exp_ovr = 1'b1;
  endfunction

  task automatic pop_check(input string nm);
    ent_t e;
    int   w;
    w = 0;
    while (rx_valid !== 1'b1 && w < 40) begin
      @(negedge clk_100M);
      w++;
    end
    if (rx_valid !== 1'b1) begin
      chk({nm, "_valid_timeout"}, {31'd0, rx_valid}, 32'd1);
      if (q.size() > 0) void'(q.pop_front());
      return;
    end
    if (q.size() == 0) begin
      chk({nm, "_unexpected_entry"}, 32'd1, 32'd0);
      e.d = 8'h00; e.f = 1'b0; e.p = 1'b0;
    end else begin
      e = q.pop_front();
    end
    chk({nm, "_data"}, {24'd0, rx_data}, {24'd0, e.d});
    chk({nm, "_ferr"}, {31'd0, rx_ferr}, {31'd0, e.f});
    chk({nm, "_perr"}, {31'd0, rx_perr}, {31'd0, e.p});
    rx_ready = 1'b1;
    @(negedge clk_100M);
    rx_ready = 1'b0;
  endtask

  task automatic drain(input string nm);
    while (q.size() > 0) pop_check(nm);
    @(negedge clk_100M);
    chk({nm, "_empty"}, {31'd0, rx_valid}, 32'd0);
  endtask

  task automatic pulse_clr();
    @(negedge clk_100M);
    clr = 1'b1;
    @(negedge clk_100M);
    clr = 1'b0;
    exp_cnt = 0;
    exp_ovr = 1'b0;
  endtask

  task automatic chk_status(input string nm);
    chk({nm, "_cnt"}, {16'd0, frame_cnt}, exp_cnt);
    chk({nm, "_ovr"}, {31'd0, ovr}, {31'd0, exp_ovr});
  endtask

  tv_t tv[$];

  initial begin
    tv.push_back('{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0});
    tv.push_back('{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1});
    tv.push_back('{8'h55, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0});
    tv.push_back('{8'h0F, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0});
    tv.push_back('{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1});
    tv.push_back('{8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0});
    tv.push_back('{8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1});
`ifndef UART_RX_MON_BREAK_DET_EN
    tv.push_back('{8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0});
`endif

    rxd = 1'b1; rx_ready = 1'b0; clr = 1'b0; ck_rst_n = 1'b0;
    repeat (4) @(negedge clk_100M);
    ck_rst_n = 1'b1;
    @(negedge clk_100M);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_data", {24'd0, rx_data}, 32'd0);
    chk("rst_ferr", {31'd0, rx_ferr}, 32'd0);
    chk("rst_perr", {31'd0, rx_perr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk_status("rst");

    // First frame into an empty FIFO: valid must rise exactly after PUSH.
    send_frame(8'hA5, 1'b0, 1'b0, 0, -1, -1, -1);
    model_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    chk("lat_valid_in_push", {31'd0, v_push}, 32'd0);
    chk("lat_valid_after_push", {31'd0, v_after}, 32'd1);
    chk_status("first");
    pop_check("first");

    // Table of single frames, each popped before the next.
    for (int i = 0; i < tv.size(); i++) begin
      ent_t e;
      send_frame(tv[i].d, tv[i].pb, tv[i].sb, DIV, -1, -1, -1);
      exp_cnt++;
      e.d = tv[i].ed; e.f = tv[i].ef; e.p = tv[i].ep;
      q.push_back(e);
      pop_check($sformatf("tv%0d", i));
      chk($sformatf("tv%0d_cnt", i), {16'd0, frame_cnt}, exp_cnt);
    end

    // Overrun: nine back-to-back frames with no reads.
    pulse_clr();
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b0, 1'b0, 0, -1, -1, -1);
      model_frame(8'(i), 1'b0, 1'b0, 1'b0);
    end
    chk_status("ovr9");
    drain("ovr9");
    pulse_clr();
    chk_status("ovr9_clr");

    // Full FIFO with a pop in the PUSH cycle: entry accepted, no overrun.
    for (int i = 0; i < 8; i++) begin
      send_frame(8'h20 + 8'(i), 1'b0, 1'b0, 0, -1, -1, -1);
      model_frame(8'h20 + 8'(i), 1'b0, 1'b0, 1'b0);
    end
    send_frame(8'h99, 1'b0, 1'b0, 0, PUSH_C, -1, -1);
    model_frame(8'h99, 1'b0, 1'b0, 1'b1);
    chk_status("full_pop");
    drain("full_pop");

    // clr in the PUSH cycle of an overrunning frame wins over set and increment.
    pulse_clr();
    for (int i = 0; i < 8; i++) begin
      send_frame(8'h40 + 8'(i), 1'b1, 1'b0, 0, -1, -1, -1);
      model_frame(8'h40 + 8'(i), 1'b1, 1'b0, 1'b0);
    end
    send_frame(8'h77, 1'b0, 1'b0, 0, -1, PUSH_C, -1);
    model_frame(8'h77, 1'b0, 1'b0, 1'b0);
    exp_cnt = 0;
    exp_ovr = 1'b0;
    @(negedge clk_100M);
    chk_status("clr_prio");
    drain("clr_prio");

    // Short low glitch must be rejected at the start-bit sample.
    for (int c = 0; c < DIV / 4; c++) begin
      @(negedge clk_100M);
      rxd = 1'b0;
    end
    for (int c = 0; c < 2 * DIV; c++) begin
      @(negedge clk_100M);
      rxd = 1'b1;
    end
    chk("glitch_busy", {31'd0, busy}, 32'd0);
    chk("glitch_valid", {31'd0, rx_valid}, 32'd0);
    chk_status("glitch");

    // Reset during bit 4 of 0xFF with one entry already buffered.
    send_frame(8'h33, 1'b0, 1'b0, 4, -1, -1, -1);
    send_frame(8'hFF, 1'b0, 1'b0, 0, -1, -1, 5 * DIV + DIV / 2);
    ck_rst_n = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge clk_100M);
    ck_rst_n = 1'b1;
    q.delete();
    exp_cnt = 0;
    exp_ovr = 1'b0;
    @(negedge clk_100M);
    chk("midrst_valid", {31'd0, rx_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk_status("midrst");
    send_frame(8'h12, 1'b0, 1'b0, 0, -1, -1, -1);
    model_frame(8'h12, 1'b0, 1'b0, 1'b0);
    chk_status("after_rst");
    pop_check("after_rst");

`ifdef UART_RX_MON_BREAK_DET_EN
    // Long break: one brk pulse, no FIFO write, counted as a frame.
    pulse_clr();
    brk_cnt = 0;
    exp_brk = 0;
    for (int c = 0; c < 12 * DIV; c++) begin
      @(negedge clk_100M);
      rxd = 1'b0;
    end
    chk("brk_busy_hold", {31'd0, busy}, 32'd1);
    for (int c = 0; c < 2 * DIV; c++) begin
      @(negedge clk_100M);
      rxd = 1'b1;
    end
    exp_cnt = 1;
    chk("brk_pulses", brk_cnt, 32'd1);
    chk("brk_valid", {31'd0, rx_valid}, 32'd0);
    chk_status("brk");
    send_frame(8'h7E, 1'b0, 1'b0, 0, -1, -1, -1);
    model_frame(8'h7E, 1'b0, 1'b0, 1'b0);
    pop_check("after_brk");
    brk_cnt = 0;
`endif

    // Randomised bursts against the queue model.
    for (int r = 0; r < 6; r++) begin
      int n;
      pulse_clr();
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++) begin
        logic [7:0] d;
        bit pb, sb;
        int tail;
        d  = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) d = 8'h00;
        pb = ($urandom_range(0, 3) == 0);
        sb = ($urandom_range(0, 3) == 0);
        tail = sb ? $urandom_range(8, 2 * DIV) : $urandom_range(0, DIV);
        send_frame(d, pb, sb, tail, -1, -1, -1);
        model_frame(d, pb, sb, 1'b0);
      end
      chk_status($sformatf("rnd%0d", r));
`ifdef UART_RX_MON_BREAK_DET_EN
      chk($sformatf("rnd%0d_brk", r), brk_cnt, exp_brk);
`endif
      drain($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_mon.md
Name: uart_rx_mon

Overview:
- Clocked, parametrised UART receiver for SoC benches and FPGA debug. Next generation of the bench UART RX model.
- Samples a serial line and decodes frames with configurable data bits, parity and stop bits.
- Buffers received characters with per-character error flags in a FIFO, read through a valid/ready port.
- Keeps sticky status: overrun flag and received-frame counter. A bench checker or a CSR block drains it.

Parameters:
- CLK_HZ, 100000000, clock frequency in Hz.
- BAUDRATE, 115200, line rate. DIV = (CLK_HZ + BAUDRATE/2) / BAUDRATE clocks per bit; DIV must be >= 8.
- DATA_BITS, 8, data bits per frame, 5..9, LSB first.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.
- FIFO_DEPTH, 8, entries, power of two, >= 2.
- CNT_W, 16, width of the frame counter.

Ports:
- clk_100M  in  1  clock. The name is fixed; the frequency is given by CLK_HZ.
- ck_rst_n  in  1  synchronous reset, active low.
- rxd  in  1  serial input, asynchronous, idle high.
- rx_data  out  DATA_BITS  head-of-FIFO character.
- rx_ferr  out  1  head entry: stop-bit (framing) error.
- rx_perr  out  1  head entry: parity error. Always 0 when PARITY = 0.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  pop the head when rx_valid && rx_ready.
- ovr  out  1  sticky overrun flag.
- clr  in  1  clears ovr and frame_cnt. Takes priority over a same-cycle set or increment.
- frame_cnt  out  CNT_W  frames completed, including errored and dropped frames. Wraps modulo 2^CNT_W.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (ck_rst_n low at a clk_100M edge):
  - FSM goes to IDLE.
  - FIFO is emptied; rx_valid = 0. rx_data, rx_ferr and rx_perr read 0.
  - ovr = 0, frame_cnt = 0, busy = 0.
  - Synchroniser flops preset to 1.
  - A frame in progress when reset is asserted is discarded; no entry is written.
- rxd passes through a 2-flop synchroniser, giving rxs. All sampling uses rxs.
- Bit timer: counter 0..DIV-1. Each bit is sampled at count DIV/2 (integer division).
- FSM states and transitions:
  - IDLE: on a falling edge of rxs -> START, timer cleared.
  - START: at the half-bit point, if rxs = 1 (glitch) -> IDLE with no push; otherwise -> DATA, bit index = 0.
  - DATA: one sample per bit period, shifted in LSB first. After DATA_BITS samples -> PARITY if PARITY != 0, else -> STOP.
  - PARITY: sample the parity bit. perr = 1 when the received parity does not match: XOR of data and parity bit must be 1 for odd, 0 for even.
  - STOP: sample STOP_BITS stop bits; ferr = 1 if any stop sample is 0. After the last stop sample -> PUSH.
  - PUSH: lasts one cycle; writes {data, ferr, perr}; frame_cnt increments; -> IDLE.
- Resync: IDLE can detect the next start edge from the cycle after PUSH, i.e. half a bit before the nominal stop end. Back-to-back frames are accepted.
- FIFO:
  - Write in PUSH, read on rx_valid && rx_ready. Both can happen in one cycle.
  - rx_data, rx_ferr and rx_perr are valid whenever rx_valid = 1 and hold steady until popped.
  - Write to an empty FIFO: rx_valid rises the cycle after PUSH (1-cycle latency).
  - Simultaneous push and pop:
    - FIFO full: the pop frees a slot and the push is accepted; no overrun.
    - FIFO empty: the new entry appears the next cycle.
  - Push while full without a pop: the entry is dropped, ovr is set, frame_cnt still increments.
  - Pop while empty: ignored.
- Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.

Optional Feature:
- Macro UART_RX_MON_BREAK_DET_EN.
- Enabled:
  - Adds output port brk (1-bit, 1-cycle pulse).
  - A frame whose data bits, parity bit and all stop samples are all 0 is a break. brk pulses in PUSH; no FIFO write; frame_cnt increments.
  - The FSM then waits in a BRK state until rxs = 1, then -> IDLE. This prevents spurious start detection during a long break.
- Disabled:
  - No brk port, no BRK state.
  - A break frame is pushed as data 0 with ferr = 1 (and perr as computed).

Test Plan:
- Defaults (DIV = 868): send 0xA5, 8N1 -> one entry 0xA5, ferr = 0, perr = 0. rx_valid rises 1 cycle after PUSH. frame_cnt = 1.
- PARITY = 2: send 0x3C with correct parity bit 0 -> perr = 0. Repeat with parity bit 1 -> 0x3C with perr = 1.
- Send 0x55 with the stop bit driven 0, then line idle -> entry 0x55 with ferr = 1; the next frame 0x0F decodes correctly.
- rx_ready = 0: send 9 frames 0x01..0x09 -> FIFO holds 0x01..0x08, ovr = 1, frame_cnt = 9. Pop all 8 in order. Pulse clr -> ovr = 0, frame_cnt = 0.
- Low pulse of 200 clocks on rxd -> start rejected, no entry. Reset asserted mid-frame at bit 4 of 0xFF -> FIFO empty, then the next frame 0x12 is received correctly.
- UART_RX_MON_BREAK_DET_EN defined: hold rxd low 12 bit times -> brk pulses once, no FIFO write, frame_cnt = 1. After rxd returns high, 0x7E is received correctly.
